// File: rtl/cpu_pkg.sv
// Shared encodings and control-bundle layout for the ARM-subset decode path.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 15;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] REG_PC  = 4'd15;
    localparam logic [3:0] REG_LR  = 4'd14;

    typedef struct packed {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
    } ctrl_t;

endpackage

// File: rtl/instr_fields.sv
// Combinational field extraction: read addresses, hazard sources, destination and immediate.
module instr_fields
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] instr,
    output logic [3:0]        a1,
    output logic [3:0]        a2,
    output logic [3:0]        src1,
    output logic              src1_en,
    output logic [3:0]        src2,
    output logic              src2_en,
    output logic [3:0]        wa3,
    output logic              we,
    output logic [DATA_W-1:0] imm,
    output logic [11:0]       ctrl
);

    ctrl_t      fields;
    logic [3:0] rn;
    logic [3:0] rd;
    logic [3:0] rm;

    assign fields = ctrl_t'({instr[31:28], instr[27:26], instr[25:20]});
    assign ctrl   = fields;
    assign rn     = instr[19:16];
    assign rd     = instr[15:12];
    assign rm     = instr[3:0];

    always_comb begin
        a1      = rn;
        a2      = rm;
        src1    = rn;
        src1_en = 1'b0;
        src2    = rm;
        src2_en = 1'b0;
        wa3     = rd;
        we      = 1'b0;
        imm     = '0;
        unique case (op_e'(fields.op))
            OP_DP: begin
                src1_en = 1'b1;
                src2_en = ~fields.funct[5];
                we      = ~(fields.funct[4:1] == CMD_CMP || fields.funct[4:1] == CMD_CMN);
                imm     = {{(DATA_W-8){1'b0}}, instr[7:0]};
            end
            OP_MEM: begin
                a2      = rd;
                src2    = rd;
                src1_en = 1'b1;
                // STR reads Rd as store data; LDR writes it instead.
                src2_en = ~fields.funct[0];
                we      = fields.funct[0];
                imm     = {{(DATA_W-12){1'b0}}, instr[11:0]};
            end
            OP_BR: begin
                a1  = REG_PC;
                a2  = 4'd0;
                wa3 = REG_LR;
                we  = fields.funct[4];
                imm = {{(DATA_W-26){instr[23]}}, instr[23:0], 2'b00};
            end
            OP_NOP: begin
                wa3 = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: pending-write scoreboard for RAW/WAW stalls and the ID/EX pipeline register.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic [3:0]        a1,
    output logic [3:0]        a2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic [3:0]        wb_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_imm,
    output logic [11:0]       out_ctrl,
    output logic [3:0]        out_wa3,
    output logic              out_we
);

    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [3:0]        wa3;
    logic              src1_en;
    logic              src2_en;
    logic              we;
    logic [DATA_W-1:0] imm;
    logic [11:0]       ctrl;

    logic [14:0] pend_q;
    logic [14:0] pend_d;
    logic [14:0] wb_clr;
    logic [14:0] issue_set;
    logic [14:0] pend_eff;
    logic [15:0] pend_ext;
    logic        hazard;
    logic        fire_in;

    instr_fields #(
        .DATA_W (DATA_W)
    ) u_fields (
        .instr   (in_instr),
        .a1      (a1),
        .a2      (a2),
        .src1    (src1),
        .src1_en (src1_en),
        .src2    (src2),
        .src2_en (src2_en),
        .wa3     (wa3),
        .we      (we),
        .imm     (imm),
        .ctrl    (ctrl)
    );

    // Shifting by 15 drops out of the 15-bit vector, so r15 never sets or clears a bit.
    assign wb_clr    = wb_valid ? (15'(1) << wb_addr) : '0;
    assign issue_set = (fire_in && we) ? (15'(1) << wa3) : '0;

    // Same-cycle write-back is already visible on rd1/rd2, so it does not block issue.
    assign pend_eff = pend_q & ~wb_clr;
    assign pend_ext = {1'b0, pend_eff};

    assign hazard = (src1_en && pend_ext[src1]) ||
                    (src2_en && pend_ext[src2]) ||
                    (we && pend_ext[wa3]);

    assign in_ready = rst_n && !hazard && !flush && (!out_valid || out_ready);
    assign fire_in  = in_valid && in_ready;
    assign pend_d   = pend_eff | issue_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q    <= '0;
            out_valid <= 1'b0;
            out_op1   <= '0;
            out_op2   <= '0;
            out_imm   <= '0;
            out_ctrl  <= '0;
            out_wa3   <= '0;
            out_we    <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (fire_in) begin
                out_valid <= 1'b1;
                out_op1   <= rd1;
                out_op2   <= rd2;
                out_imm   <= imm;
                out_ctrl  <= ctrl;
                out_wa3   <= wa3;
                out_we    <= we;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, RAW stall, back-pressure, branch, flush, set/clear race.
module tb_decode_stage;

    localparam logic [31:0] I_ADD_1_2_3 = 32'hE0821003;
    localparam logic [31:0] I_ADD_6_2_3 = 32'hE0826003;
    localparam logic [31:0] I_SUB_4_1_5 = 32'hE0414005;
    localparam logic [31:0] I_SUB_4_7_5 = 32'hE0474005;
    localparam logic [31:0] I_CMP_0_1   = 32'hE1500001;
    localparam logic [31:0] I_LDR_7     = 32'hE5907004;
    localparam logic [31:0] I_LDR_2     = 32'hE5902000;
    localparam logic [31:0] I_BL_M4     = 32'hEBFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        flush;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1;
    logic [31:0] out_op2;
    logic [31:0] out_imm;
    logic [11:0] out_ctrl;
    logic [3:0]  out_wa3;
    logic        out_we;

    int passed = 0;
    int total  = 0;

    decode_stage #(
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .a1        (a1),
        .a2        (a2),
        .rd1       (rd1),
        .rd2       (rd2),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op1   (out_op1),
        .out_op2   (out_op2),
        .out_imm   (out_imm),
        .out_ctrl  (out_ctrl),
        .out_wa3   (out_wa3),
        .out_we    (out_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_instr = I_ADD_1_2_3; rd1 = 32'h1111; rd2 = 32'h2222;
        flush = 1'b0; wb_valid = 1'b0; wb_addr = 4'd0; out_ready = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0h exp=0", out_valid); else passed++;
        total++; if (dut.pend_q !== 15'h0) $display("FAIL reset_pend got=%0h exp=0", dut.pend_q); else passed++;
        total++; if ({out_op1, out_op2, out_imm} !== 96'h0) $display("FAIL reset_data got=%0h/%0h/%0h exp=0", out_op1, out_op2, out_imm); else passed++;
        total++; if ({out_ctrl, out_wa3, out_we} !== 17'h0) $display("FAIL reset_ctrl got=%0h/%0h/%0h exp=0", out_ctrl, out_wa3, out_we); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%0h exp=0", in_ready); else passed++;
        rst_n = 1'b1;
        #1;
        total++; if (a1 !== 4'd2 || a2 !== 4'd3) $display("FAIL add_addr got=%0d/%0d exp=2/3", a1, a2); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL add_in_ready got=%0h exp=1", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b1) $display("FAIL add_out_valid got=%0h exp=1", out_valid); else passed++;
        total++; if (out_op1 !== 32'h1111 || out_op2 !== 32'h2222) $display("FAIL add_ops got=%0h/%0h exp=1111/2222", out_op1, out_op2); else passed++;
        total++; if (out_wa3 !== 4'd1 || out_we !== 1'b1) $display("FAIL add_dest got=%0d/%0h exp=1/1", out_wa3, out_we); else passed++;
        total++; if (out_ctrl !== 12'hE08 || out_imm !== 32'h3) $display("FAIL add_ctrl_imm got=%0h/%0h exp=e08/3", out_ctrl, out_imm); else passed++;
        total++; if (dut.pend_q !== 15'h0002) $display("FAIL add_pend got=%0h exp=2", dut.pend_q); else passed++;
    endtask

    task automatic test_raw_stall();
        in_instr = I_SUB_4_1_5; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL raw_stall_0 got=%0h exp=0", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL raw_stall_1 got=%0h/%0h exp=0/0", out_valid, in_ready); else passed++;
        wb_valid = 1'b1; wb_addr = 4'd1; rd1 = 32'h3333;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL raw_wb_release got=%0h exp=1", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_wa3 !== 4'd4 || out_op1 !== 32'h3333) $display("FAIL raw_issue got=%0h/%0d/%0h exp=1/4/3333", out_valid, out_wa3, out_op1); else passed++;
        total++; if (dut.pend_q !== 15'h0010) $display("FAIL raw_pend got=%0h exp=10", dut.pend_q); else passed++;
        in_valid = 1'b0; wb_addr = 4'd4;
        tick();
        wb_valid = 1'b0;
        total++; if (dut.pend_q !== 15'h0) $display("FAIL raw_retire got=%0h exp=0", dut.pend_q); else passed++;
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADD_1_2_3; rd1 = 32'hAAAA;
        tick();
        in_instr = I_ADD_6_2_3; rd1 = 32'hBBBB;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); else passed++;
            tick();
            total++; if (out_valid !== 1'b1 || out_op1 !== 32'hAAAA || out_wa3 !== 4'd1) $display("FAIL bp_hold[%0d] got=%0h/%0h/%0d exp=1/aaaa/1", i, out_valid, out_op1, out_wa3); else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL bp_release got=%0h exp=1", in_ready); else passed++;
        tick();
        total++; if (out_wa3 !== 4'd6 || out_op1 !== 32'hBBBB) $display("FAIL bp_next got=%0d/%0h exp=6/bbbb", out_wa3, out_op1); else passed++;
        in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 4'd1;
        tick();
        wb_addr = 4'd6;
        tick();
        wb_valid = 1'b0;
        total++; if (dut.pend_q !== 15'h0) $display("FAIL bp_retire got=%0h exp=0", dut.pend_q); else passed++;
    endtask

    task automatic test_branch();
        in_valid = 1'b1; in_instr = I_BL_M4; out_ready = 1'b1;
        #1;
        total++; if (a1 !== 4'd15 || a2 !== 4'd0 || in_ready !== 1'b1) $display("FAIL bl_addr got=%0d/%0d/%0h exp=15/0/1", a1, a2, in_ready); else passed++;
        tick();
        total++; if (out_imm !== 32'hFFFFFFFC) $display("FAIL bl_imm got=%0h exp=fffffffc", out_imm); else passed++;
        total++; if (out_wa3 !== 4'd14 || out_we !== 1'b1 || out_ctrl !== 12'hEBF) $display("FAIL bl_dest got=%0d/%0h/%0h exp=14/1/ebf", out_wa3, out_we, out_ctrl); else passed++;
        total++; if (dut.pend_q !== 15'h4000) $display("FAIL bl_pend got=%0h exp=4000", dut.pend_q); else passed++;
        in_instr = I_CMP_0_1;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL cmp_in_ready got=%0h exp=1", in_ready); else passed++;
        tick();
        total++; if (out_valid !== 1'b1 || out_we !== 1'b0) $display("FAIL cmp_we got=%0h/%0h exp=1/0", out_valid, out_we); else passed++;
        total++; if (dut.pend_q !== 15'h4000) $display("FAIL cmp_pend got=%0h exp=4000", dut.pend_q); else passed++;
        in_valid = 1'b0; wb_valid = 1'b1; wb_addr = 4'd14;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_instr = I_LDR_7; out_ready = 1'b1;
        tick();
        total++; if (out_imm !== 32'h4 || out_we !== 1'b1 || out_wa3 !== 4'd7) $display("FAIL ldr_fields got=%0h/%0h/%0d exp=4/1/7", out_imm, out_we, out_wa3); else passed++;
        total++; if (dut.pend_q !== 15'h0080) $display("FAIL ldr_pend got=%0h exp=80", dut.pend_q); else passed++;
        out_ready = 1'b0; in_instr = I_ADD_1_2_3; flush = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got=%0h exp=0", in_ready); else passed++;
        tick();
        flush = 1'b0;
        total++; if (out_valid !== 1'b0 || dut.pend_q !== 15'h0080) $display("FAIL flush_kill got=%0h/%0h exp=0/80", out_valid, dut.pend_q); else passed++;
        in_instr = I_SUB_4_7_5; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_r7_stall got=%0h exp=0", in_ready); else passed++;
        wb_valid = 1'b1; wb_addr = 4'd7;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_r7_release got=%0h exp=1", in_ready); else passed++;
        tick();
        in_valid = 1'b0; wb_addr = 4'd4;
        total++; if (out_wa3 !== 4'd4 || dut.pend_q !== 15'h0010) $display("FAIL flush_sub got=%0d/%0h exp=4/10", out_wa3, dut.pend_q); else passed++;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        in_valid = 1'b1; in_instr = I_LDR_2; out_ready = 1'b1;
        tick();
        total++; if (dut.pend_q !== 15'h0004) $display("FAIL sc_first got=%0h exp=4", dut.pend_q); else passed++;
        wb_valid = 1'b1; wb_addr = 4'd2;
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL sc_in_ready got=%0h exp=1", in_ready); else passed++;
        tick();
        total++; if (dut.pend_q !== 15'h0004 || out_wa3 !== 4'd2) $display("FAIL sc_set_wins got=%0h/%0d exp=4/2", dut.pend_q, out_wa3); else passed++;
        in_valid = 1'b0; wb_addr = 4'd9;
        tick();
        total++; if (dut.pend_q !== 15'h0004) $display("FAIL sc_wb_noop got=%0h exp=4", dut.pend_q); else passed++;
        wb_addr = 4'd2;
        tick();
        wb_valid = 1'b0;
        total++; if (dut.pend_q !== 15'h0 || out_valid !== 1'b0) $display("FAIL sc_drain got=%0h/%0h exp=0/0", dut.pend_q, out_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_raw_stall();
        test_back_pressure();
        test_branch();
        test_flush();
        test_same_cycle();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
